// File: rtl/ram_write_router_if.sv
// Bundle of the two DMA buffer streams and the six per-bank write ports.
// The buffers and the bench drive it through the master side. The router
// drives the bank writes through the slave side.
interface ram_write_router_if #(
  parameter int DD_WIDTH       = 16,
  parameter int RAM_ADDR_WIDTH = 4
);
  logic [DD_WIDTH-1:0]         ch1_data;
  logic [RAM_ADDR_WIDTH-1:0]   ch1_addr;
  logic [2:0]                  ch1_sel;
  logic                        ch1_valid;
  logic [DD_WIDTH-1:0]         ch2_data;
  logic [RAM_ADDR_WIDTH-1:0]   ch2_addr;
  logic [2:0]                  ch2_sel;
  logic                        ch2_valid;
  logic [5:0]                  bank_we;
  logic [6*RAM_ADDR_WIDTH-1:0] bank_waddr;
  logic [6*DD_WIDTH-1:0]       bank_wdata;

  modport master (
    output ch1_data, ch1_addr, ch1_sel, ch1_valid,
    output ch2_data, ch2_addr, ch2_sel, ch2_valid,
    input  bank_we, bank_waddr, bank_wdata
  );

  modport slave (
    input  ch1_data, ch1_addr, ch1_sel, ch1_valid,
    input  ch2_data, ch2_addr, ch2_sel, ch2_valid,
    output bank_we, bank_waddr, bank_wdata
  );
endinterface

// File: rtl/ram_write_router.sv
// Routes the two DMA buffer streams into six on-chip RAM banks.
// Channel 1 always has priority. A channel-2 word that collides with channel 1
// is parked in a small FIFO so that channel-2 order is kept.
// Per-bank word counters report when the banks of the current load are full.
module ram_write_router #(
  parameter int DD_WIDTH       = 16,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int QDEPTH         = 4   // power of two, at least 2
) (
  input  logic               clk_h,
  input  logic               rst_h,
  input  logic               load_start,
  input  logic [5:0]         bank_mask,
  ram_write_router_if.slave  wr,
  output logic [5:0]         bank_full,
  output logic               busy,
  output logic               load_done,
  output logic               ovf_err,
  output logic               sel_err
);
  localparam int NBANK = 6;
  localparam int QAW   = $clog2(QDEPTH);
  localparam int QW    = 3 + RAM_ADDR_WIDTH + DD_WIDTH;
  localparam logic [RAM_ADDR_WIDTH:0] FULL_CNT = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
  localparam logic [QAW:0]            Q_FULL   = {1'b1, {QAW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
  state_t state_reg, state_next;

  // Select codes 001..110 name a bank. 000 and 111 carry no bank.
  function automatic logic sel_ok(input logic [2:0] s);
    return (s != 3'b000) && (s != 3'b111);
  endfunction

  // Input stage registers
  logic                      ch1_v_reg, ch2_v_reg;
  logic [2:0]                ch1_sel_reg, ch2_sel_reg;
  logic [RAM_ADDR_WIDTH-1:0] ch1_addr_reg, ch2_addr_reg;
  logic [DD_WIDTH-1:0]       ch1_data_reg, ch2_data_reg;
  logic [5:0]                mask_reg;

  // Channel-2 collision queue
  logic [QW-1:0]  q_mem [QDEPTH];
  logic [QAW-1:0] q_wr_ptr_reg, q_rd_ptr_reg;
  logic [QAW:0]   q_cnt_reg;

  logic                      accept_w, wr_gate;
  logic                      ch1_hit, ch2_hit, ch2_direct, ch2_want_q;
  logic [2:0]                ch1_bank, ch2_bank, head_bank;
  logic [RAM_ADDR_WIDTH-1:0] head_addr;
  logic [DD_WIDTH-1:0]       head_data;
  logic                      q_empty, q_full, q_pop, q_push;
  logic [5:0]                we_w, blk_w;
  logic [6*RAM_ADDR_WIDTH-1:0] waddr_w;
  logic [6*DD_WIDTH-1:0]       wdata_w;
  logic                      ovf_hit, sel_hit;

  // Words are taken only while a load is running. The word that arrives with
  // load_start belongs to the aborted load, so it is not taken.
  assign accept_w = (state_reg == ST_LOAD) && !load_start;
  // No bank writes happen in a restart cycle or a reset cycle.
  assign wr_gate  = !load_start && !rst_h;

  assign ch1_bank  = ch1_sel_reg - 3'd1;
  assign ch2_bank  = ch2_sel_reg - 3'd1;
  assign ch1_hit   = wr_gate && ch1_v_reg && sel_ok(ch1_sel_reg);
  assign ch2_hit   = wr_gate && ch2_v_reg && sel_ok(ch2_sel_reg);

  assign q_empty   = (q_cnt_reg == '0);
  assign q_full    = (q_cnt_reg == Q_FULL);
  assign head_bank = q_mem[q_rd_ptr_reg][QW-1 -: 3];
  assign head_addr = q_mem[q_rd_ptr_reg][DD_WIDTH +: RAM_ADDR_WIDTH];
  assign head_data = q_mem[q_rd_ptr_reg][DD_WIDTH-1:0];

  // The queue head drains whenever channel 1 is not using the head's bank.
  assign q_pop      = wr_gate && !q_empty && !(ch1_hit && ch1_bank == head_bank);
  // Channel 2 bypasses the queue only if this keeps its order and avoids channel 1.
  assign ch2_direct = ch2_hit && q_empty && !(ch1_hit && ch1_bank == ch2_bank);
  assign ch2_want_q = ch2_hit && !ch2_direct;
  assign q_push     = ch2_want_q && (!q_full || q_pop);

  assign ovf_hit = (|blk_w) || (ch2_want_q && !q_push);
  assign sel_hit = wr_gate && ((ch1_v_reg && ch1_sel_reg == 3'b111) ||
                               (ch2_v_reg && ch2_sel_reg == 3'b111));

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    logic                      tgt;
    logic [RAM_ADDR_WIDTH-1:0] addr_sel;
    logic [DD_WIDTH-1:0]       data_sel;
    logic [RAM_ADDR_WIDTH:0]   cnt_reg;
    logic [RAM_ADDR_WIDTH-1:0] waddr_reg;
    logic [DD_WIDTH-1:0]       wdata_reg;

    // Pick this bank's writer. Arbitration above lets at most one source hit a bank.
    always_comb begin
      tgt      = 1'b0;
      addr_sel = '0;
      data_sel = '0;
      if (ch1_hit && ch1_bank == 3'(gi)) begin
        tgt      = 1'b1;
        addr_sel = ch1_addr_reg;
        data_sel = ch1_data_reg;
      end else if (ch2_direct && ch2_bank == 3'(gi)) begin
        tgt      = 1'b1;
        addr_sel = ch2_addr_reg;
        data_sel = ch2_data_reg;
      end else if (q_pop && head_bank == 3'(gi)) begin
        tgt      = 1'b1;
        addr_sel = head_addr;
        data_sel = head_data;
      end
    end

    assign bank_full[gi] = (cnt_reg == FULL_CNT);
    assign we_w[gi]      = tgt && !bank_full[gi];
    assign blk_w[gi]     = tgt && bank_full[gi];
    assign waddr_w[gi*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH] = we_w[gi] ? addr_sel : waddr_reg;
    assign wdata_w[gi*DD_WIDTH +: DD_WIDTH]             = we_w[gi] ? data_sel : wdata_reg;

    // Count the writes and keep the last address/data so idle slices hold their value.
    always_ff @(posedge clk_h) begin
      if (rst_h) begin
        cnt_reg   <= '0;
        waddr_reg <= '0;
        wdata_reg <= '0;
      end else begin
        if (load_start)
          cnt_reg <= '0;
        else if (we_w[gi])
          cnt_reg <= cnt_reg + 1'b1;
        if (we_w[gi]) begin
          waddr_reg <= addr_sel;
          wdata_reg <= data_sel;
        end
      end
    end
  end

  assign wr.bank_we    = we_w;
  assign wr.bank_waddr = waddr_w;
  assign wr.bank_wdata = wdata_w;

  // Register each channel once. Valid is qualified by the load window.
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      ch1_v_reg    <= 1'b0;
      ch2_v_reg    <= 1'b0;
      ch1_sel_reg  <= '0;
      ch2_sel_reg  <= '0;
      ch1_addr_reg <= '0;
      ch2_addr_reg <= '0;
      ch1_data_reg <= '0;
      ch2_data_reg <= '0;
    end else begin
      ch1_v_reg    <= wr.ch1_valid && accept_w;
      ch2_v_reg    <= wr.ch2_valid && accept_w;
      ch1_sel_reg  <= wr.ch1_sel;
      ch2_sel_reg  <= wr.ch2_sel;
      ch1_addr_reg <= wr.ch1_addr;
      ch2_addr_reg <= wr.ch2_addr;
      ch1_data_reg <= wr.ch1_data;
      ch2_data_reg <= wr.ch2_data;
    end
  end

  // Queue pointers, mask latch and sticky errors. A load_start flushes and re-arms.
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_cnt_reg    <= '0;
      mask_reg     <= '0;
      ovf_err      <= 1'b0;
      sel_err      <= 1'b0;
    end else if (load_start) begin
      q_wr_ptr_reg <= '0;
      q_rd_ptr_reg <= '0;
      q_cnt_reg    <= '0;
      mask_reg     <= bank_mask;
      ovf_err      <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      if (q_push)
        q_wr_ptr_reg <= q_wr_ptr_reg + 1'b1;
      if (q_pop)
        q_rd_ptr_reg <= q_rd_ptr_reg + 1'b1;
      if (q_push && !q_pop)
        q_cnt_reg <= q_cnt_reg + 1'b1;
      else if (q_pop && !q_push)
        q_cnt_reg <= q_cnt_reg - 1'b1;
      if (ovf_hit)
        ovf_err <= 1'b1;
      if (sel_hit)
        sel_err <= 1'b1;
    end
  end

  // Queue storage. Its contents are don't-care while the queue is empty.
  always_ff @(posedge clk_h) begin
    if (q_push)
      q_mem[q_wr_ptr_reg] <= {ch2_bank, ch2_addr_reg, ch2_data_reg};
  end

  // FSM state register
  always_ff @(posedge clk_h) begin
    if (rst_h)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // FSM next state. A load_start in any state (re)starts a load.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (load_start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (load_start)
          state_next = ST_LOAD;
        else if (((bank_full & mask_reg) == mask_reg) && q_empty)
          state_next = ST_DONE;
      end
      ST_DONE: state_next = load_start ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_reg == ST_LOAD);
    load_done = (state_reg == ST_DONE);
  end
endmodule

// File: tb/tb_ram_write_router.sv
// Scoreboard bench for ram_write_router. Expected bank writes are queued per
// bank as stimulus is driven. A negedge monitor pops and checks them, including
// the cycle in which each write must appear.
module tb_ram_write_router;
  logic       clk_h;
  logic       rst_h;
  logic       load_start;
  logic [5:0] bank_mask;
  logic [5:0] bank_full;
  logic       busy, load_done, ovf_err, sel_err;

  ram_write_router_if #(.DD_WIDTH(16), .RAM_ADDR_WIDTH(4)) wif ();

  ram_write_router #(.DD_WIDTH(16), .RAM_ADDR_WIDTH(4), .QDEPTH(4)) dut (
    .clk_h      (clk_h),
    .rst_h      (rst_h),
    .load_start (load_start),
    .bank_mask  (bank_mask),
    .wr         (wif),
    .bank_full  (bank_full),
    .busy       (busy),
    .load_done  (load_done),
    .ovf_err    (ovf_err),
    .sel_err    (sel_err)
  );

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[6][$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   wr_cnt[6] = '{0, 0, 0, 0, 0, 0};
  int   done_cnt = 0;

  always @(posedge clk_h) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int bank, input int a, input int d, input int due);
    exp_t e;
    e.addr = 4'(a);
    e.data = 16'(d);
    e.due  = due;
    sb_q[bank].push_back(e);
  endtask

  // Write monitor: every bank_we must match the head of that bank's scoreboard.
  always @(negedge clk_h) begin
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      if (wif.bank_we[k]) begin
        wr_cnt[k]++;
        $display("write bank%0d addr=%h data=%h cycle=%0d", k,
                 wif.bank_waddr[k*4 +: 4], wif.bank_wdata[k*16 +: 16], cyc);
        check_eq("sb_has_entry", 64'(sb_q[k].size() != 0), 64'd1);
        if (sb_q[k].size() != 0) begin
          e = sb_q[k].pop_front();
          check_eq("waddr", 64'(wif.bank_waddr[k*4 +: 4]), 64'(e.addr));
          check_eq("wdata", 64'(wif.bank_wdata[k*16 +: 16]), 64'(e.data));
          check_eq("w_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
    if (load_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [2:0] s1, input int a1, input int d1,
                       input logic v2, input logic [2:0] s2, input int a2, input int d2);
    wif.ch1_valid = v1;
    wif.ch1_sel   = s1;
    wif.ch1_addr  = 4'(a1);
    wif.ch1_data  = 16'(d1);
    wif.ch2_valid = v2;
    wif.ch2_sel   = s2;
    wif.ch2_addr  = 4'(a2);
    wif.ch2_data  = 16'(d2);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 3'd0, 0, 0);
  endtask

  task automatic start_load(input logic [5:0] m);
    load_start = 1'b1;
    bank_mask  = m;
    tick();
    load_start = 1'b0;
  endtask

  // Fill one bank from channel 1 and check the exact full/done timing.
  task automatic fill_bank(input int bank, input int base);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'(bank + 1), i, base + i, 1'b0, 3'd0, 0, 0);
      sb_push(bank, i, base + i, cyc + 1);
      tick();
    end
    idle();
    check_eq("full_early", 64'(bank_full[bank]), 64'd0);
    tick();
    check_eq("full_set", 64'(bank_full[bank]), 64'd1);
    check_eq("busy_load", 64'(busy), 64'd1);
    check_eq("done_early", 64'(load_done), 64'd0);
    tick();
    check_eq("done_pulse", 64'(load_done), 64'd1);
    check_eq("busy_done", 64'(busy), 64'd0);
    tick();
    check_eq("done_once", 64'(load_done), 64'd0);
  endtask

  initial begin
    int c0;
    int d0;
    rst_h      = 1'b1;
    load_start = 1'b0;
    bank_mask  = '0;
    idle();
    repeat (3) tick();
    rst_h = 1'b0;

    // Reset state
    check_eq("rst_we", 64'(wif.bank_we), 64'd0);
    check_eq("rst_waddr", 64'(wif.bank_waddr), 64'd0);
    check_eq("rst_wdata", 64'(wif.bank_wdata), 64'd0);
    check_eq("rst_full", 64'(bank_full), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(load_done), 64'd0);
    check_eq("rst_errs", 64'({ovf_err, sel_err}), 64'd0);

    // Words in IDLE are dropped
    drive(1'b1, 3'b001, 1, 16'h0BAD, 1'b1, 3'b010, 2, 16'h0BAD);
    tick();
    idle();
    tick();

    // Single-channel fill of bank0
    start_load(6'b000001);
    fill_bank(0, 16'h1000);
    check_eq("done_cnt_1", 64'(done_cnt), 64'd1);

    // Empty mask completes on its own
    start_load(6'b000000);
    check_eq("m0_busy", 64'(busy), 64'd1);
    tick();
    check_eq("m0_done", 64'(load_done), 64'd1);
    tick();

    // Parallel banks 1 and 2, no queueing
    start_load(6'b000110);
    check_eq("par_cleared", 64'(bank_full), 64'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b010, i, 16'h2000 + i, 1'b1, 3'b011, 15 - i, 16'h3000 + i);
      sb_push(1, i, 16'h2000 + i, cyc + 1);
      sb_push(2, 15 - i, 16'h3000 + i, cyc + 1);
      tick();
    end
    idle();
    check_eq("par_full_early", 64'(bank_full[2:1]), 64'd0);
    tick();
    check_eq("par_full", 64'(bank_full[2:1]), 64'd3);
    tick();
    check_eq("par_done", 64'(load_done), 64'd1);
    tick();

    // Same-bank collision on bank3
    start_load(6'b001000);
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b100, i, 16'h4000 + i, 1'b1, 3'b100, 8 + i, 16'h4100 + i);
      sb_push(3, i, 16'h4000 + i, cyc + 1);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) sb_push(3, 8 + i, 16'h4100 + i, c0 + 4 + i);
    repeat (5) tick();
    check_eq("col_errs", 64'({ovf_err, sel_err}), 64'd0);
    check_eq("col_count", 64'(wr_cnt[3]), 64'd6);

    // Queue overflow on bank4
    start_load(6'b010000);
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'b101, i, 16'h5000 + i, 1'b1, 3'b101, 8 + i, 16'h5100 + i);
      sb_push(4, i, 16'h5000 + i, cyc + 1);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) sb_push(4, 8 + i, 16'h5100 + i, c0 + 7 + i);
    repeat (6) tick();
    check_eq("ovf_set", 64'(ovf_err), 64'd1);
    check_eq("ovf_sel", 64'(sel_err), 64'd0);
    check_eq("ovf_count", 64'(wr_cnt[4]), 64'd10);

    // Restart flushes the queue and drops the word caught in the restart cycle
    start_load(6'b010000);
    check_eq("rs_ovf_clr", 64'(ovf_err), 64'd0);
    c0 = cyc;
    drive(1'b1, 3'b101, 0, 16'h7000, 1'b1, 3'b101, 0, 16'h7100);
    sb_push(4, 0, 16'h7000, c0 + 1);
    tick();
    drive(1'b1, 3'b101, 1, 16'h7001, 1'b1, 3'b101, 1, 16'h7101);
    tick();
    idle();
    start_load(6'b010000);
    drive(1'b0, 3'd0, 0, 0, 1'b1, 3'b101, 5, 16'h7200);
    sb_push(4, 5, 16'h7200, cyc + 1);
    tick();
    idle();
    repeat (3) tick();
    check_eq("rs_count", 64'(wr_cnt[4]), 64'd12);
    check_eq("rs_errs", 64'({ovf_err, sel_err}), 64'd0);

    // Error cases on bank0 with bank1 keeping the load open
    start_load(6'b000011);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b001, i, 16'h6000 + i, 1'b0, 3'd0, 0, 0);
      sb_push(0, i, 16'h6000 + i, cyc + 1);
      tick();
    end
    idle();
    repeat (2) tick();
    check_eq("err_full0", 64'(bank_full[0]), 64'd1);
    check_eq("err_busy", 64'(busy), 64'd1);
    drive(1'b1, 3'b000, 2, 16'h0F00, 1'b0, 3'd0, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    check_eq("sel000_errs", 64'({ovf_err, sel_err}), 64'd0);
    drive(1'b1, 3'b001, 0, 16'hBEEF, 1'b0, 3'd0, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    check_eq("w17_ovf", 64'(ovf_err), 64'd1);
    check_eq("w17_sel", 64'(sel_err), 64'd0);
    check_eq("w17_count", 64'(wr_cnt[0]), 64'd32);
    check_eq("hold_addr", 64'(wif.bank_waddr[3:0]), 64'hF);
    check_eq("hold_data", 64'(wif.bank_wdata[15:0]), 64'h600F);
    drive(1'b1, 3'b111, 3, 16'h0E00, 1'b0, 3'd0, 0, 0);
    tick();
    idle();
    repeat (2) tick();
    check_eq("sel111", 64'(sel_err), 64'd1);

    // Restart mid-load after 5 words, with a word arriving alongside load_start
    start_load(6'b000001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b001, i, 16'h8000 + i, 1'b0, 3'd0, 0, 0);
      sb_push(0, i, 16'h8000 + i, cyc + 1);
      tick();
    end
    idle();
    repeat (2) tick();
    d0 = done_cnt;
    drive(1'b1, 3'b001, 3, 16'hDEAD, 1'b0, 3'd0, 0, 0);
    start_load(6'b000001);
    idle();
    check_eq("rst_ld_full", 64'(bank_full), 64'd0);
    check_eq("rst_ld_errs", 64'({ovf_err, sel_err}), 64'd0);
    check_eq("rst_ld_busy", 64'(busy), 64'd1);
    fill_bank(0, 16'h9000);
    check_eq("rst_ld_done", 64'(done_cnt), 64'(d0 + 1));

    // Synchronous reset mid-fill; the in-flight fifth word must not be written
    start_load(6'b000001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b001, i, 16'hA000 + i, 1'b0, 3'd0, 0, 0);
      if (i < 4) sb_push(0, i, 16'hA000 + i, cyc + 1);
      tick();
    end
    idle();
    rst_h = 1'b1;
    d0 = done_cnt;
    tick();
    rst_h = 1'b0;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_full", 64'(bank_full), 64'd0);
    check_eq("mid_rst_waddr", 64'(wif.bank_waddr), 64'd0);
    check_eq("mid_rst_wdata", 64'(wif.bank_wdata), 64'd0);
    tick();
    check_eq("mid_rst_nodone", 64'(done_cnt), 64'(d0));
    start_load(6'b000001);
    fill_bank(0, 16'hB000);
    check_eq("mid_rst_done", 64'(done_cnt), 64'(d0 + 1));

    repeat (2) tick();
    for (int k = 0; k < 6; k++) check_eq("sb_drained", 64'(sb_q[k].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_write_router.md
Name: ram_write_router

Overview:
- Downstream of the two DMA buffers in the CNN accelerator DMA path.
- Consumes each buffer's RAM-side stream (data, address, 3-bit RAM select, ready strobe) and routes every word to one of six on-chip RAM banks.
- Resolves same-bank collisions between the two channels with a small queue.
- Counts words per bank and reports when a programmed set of banks has been fully loaded.

Parameters:
- DD_WIDTH, 16, data word width.
- RAM_ADDR_WIDTH, 4, bank address width; bank depth is 2**RAM_ADDR_WIDTH words.
- QDEPTH, 4, channel-2 collision queue depth in entries (power of two).

Ports:
- clk_h  in  1  clock, rising edge.
- rst_h  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; arms a load.
- bank_mask  in  6  banks expected in this load; sampled on load_start.
- ch1_data  in  DD_WIDTH  buffer 1 word.
- ch1_addr  in  RAM_ADDR_WIDTH  buffer 1 bank address.
- ch1_sel  in  3  buffer 1 RAM select.
- ch1_valid  in  1  buffer 1 ready strobe.
- ch2_data, ch2_addr, ch2_sel, ch2_valid  in  same widths as ch1  buffer 2 stream.
- bank_we  out  6  per-bank write enable.
- bank_waddr  out  6*RAM_ADDR_WIDTH  per-bank address; bank k occupies slice k.
- bank_wdata  out  6*DD_WIDTH  per-bank data; bank k occupies slice k.
- bank_full  out  6  per-bank loaded flag.
- busy  out  1  high in LOAD.
- load_done  out  1  one-cycle completion pulse.
- ovf_err  out  1  sticky error: write to a full bank, or queue overflow.
- sel_err  out  1  sticky error: select code 111 with valid.

Behaviour:
- Select decode: 001 -> bank0 input, 010 -> bank1 point_even, 011 -> bank2 point_odd, 100 -> bank3 v_ram, 101 -> bank4 z_ram, 110 -> bank5 bias_ram.
  - 000 with valid: word silently dropped.
  - 111 with valid: word dropped and sel_err set.
- Reset: every output 0, all counters 0, queue empty, FSM in IDLE.
- Input stage: each channel registered once. A word valid at cycle t produces bank_we at t+1 on the direct path.
- FSM states:
  - IDLE: load_start -> LOAD; counters and queue cleared; bank_mask latched.
  - LOAD: busy=1. Exits to DONE when (bank_full & mask)==mask and the queue is empty.
  - DONE: load_done=1 for exactly one cycle, then IDLE.
  - A mask of 000000 goes LOAD -> DONE on the next cycle.
- Valid words arriving in IDLE or DONE are dropped with no error.
- load_start while in LOAD restarts the load: counters cleared, queue flushed, mask re-latched. Any word registered in that same cycle is discarded.
- Arbitration, one write per bank per cycle; ch1 always has priority:
  - Registered ch2 word goes direct if its bank differs from ch1's bank and the queue is empty.
  - Otherwise the ch2 word is pushed to the queue; this preserves ch2 order.
  - Queue head is written when ch1 is not writing the head's bank that cycle, so the earliest queued write is t+2.
  - Push and pop may occur in the same cycle.
  - Push when full: word dropped and ovf_err set.
- Counters: per bank, RAM_ADDR_WIDTH+1 bits, incremented on each bank_we. bank_full = (count == 2**RAM_ADDR_WIDTH).
  - A word targeting a full bank is not written; ovf_err is set.
- Addresses: bank_waddr is passed through unchanged; the router does not check for duplicate addresses.
- Output hold: bank_waddr and bank_wdata slices hold their last value when the corresponding bank_we is 0.
- Sticky errors clear only on rst_h or load_start.
- Reset mid-load: all state returns to reset values in the next cycle; no writes are issued in that cycle.

Test Plan:
- Single-channel fill:
  - Stimulus: load_start with mask 000001; ch1 sends 16 words, sel=001, addr 0..15, data 0x1000+i.
  - Required: bank_we[0] pulses at t+1 with matching addr/data; bank_full[0] rises after the 16th write; load_done pulses one cycle later; busy falls.
- Parallel banks:
  - Stimulus: mask 000110; ch1 sel=010 and ch2 sel=011 in the same cycles, 16 words each.
  - Required: both banks written every cycle with no queue use; load_done after both are full.
- Same-bank collision:
  - Stimulus: ch1 and ch2 both sel=100 for 3 cycles, then ch1 idle.
  - Required: ch1 words written at t+1; ch2 words written in order over the following 3 cycles; no error.
- Queue overflow:
  - Stimulus: both channels sel=101 for 6 consecutive cycles with QDEPTH=4.
  - Required: ovf_err set; exactly 10 words reach bank4.
- Errors:
  - Stimulus: ch1 sel=111 with valid; a 17th word sent to bank0 after it is full; ch1 sel=000 with valid.
  - Required: sel_err=1 and ovf_err=1; the 17th word is not written; the sel=000 word produces no write and no error.
- Restart and reset:
  - Stimulus: load_start during LOAD after 5 words; separately, rst_h asserted mid-fill.
  - Required: counters return to 0; bank_full=0; queue empty; no load_done from the aborted load.
